// File: rtl/pll_lock_reset_sequencer.sv
// pll_lock_reset_sequencer: synchronizes PLL lock, qualifies it, then sequences a clean reset release.
// Optional no-lock timeout flag is enabled by defining PLL_LOCK_TIMEOUT_EN.
module pll_lock_reset_sequencer #(
    parameter int SYNC_STAGES         = 2,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int RESET_HOLD_CYCLES   = 16,
    parameter int COUNT_WIDTH         = 8,
    parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pll_locked,
    input  logic                   clear_status,
    output logic                   reset_out,
    output logic                   ready,
    output logic                   lock_lost,
    output logic [COUNT_WIDTH-1:0] lock_loss_count,
    output logic                   lock_timeout
);
    localparam int CW = $clog2((LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES ?
                                LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES) + 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(RESET_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {WAIT_LOCK, STABILIZE, HOLD_RESET, RUN} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   locked_s;

    assign locked_s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= WAIT_LOCK;
            sync            <= '0;
            cnt             <= '0;
            reset_out       <= 1'b1;
            ready           <= 1'b0;
            lock_lost       <= 1'b0;
            lock_loss_count <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pll_locked};
            if (clear_status) begin
                lock_lost       <= 1'b0;
                lock_loss_count <= '0;
            end
            case (state)
                WAIT_LOCK: begin
                    reset_out <= 1'b1;
                    ready     <= 1'b0;
                    if (locked_s) begin
                        state <= STABILIZE;
                        cnt   <= '0;
                    end
                end
                STABILIZE: begin
                    if (!locked_s) state <= WAIT_LOCK;
                    else if (cnt == STABLE_LAST) begin
                        state <= HOLD_RESET;
                        cnt   <= '0;
                    end else cnt <= cnt + 1'b1;
                end
                HOLD_RESET: begin
                    if (!locked_s) state <= WAIT_LOCK;
                    else if (cnt == HOLD_LAST) begin
                        state     <= RUN;
                        reset_out <= 1'b0;
                        ready     <= 1'b1;
                    end else cnt <= cnt + 1'b1;
                end
                RUN: begin
                    // A loss outranks a simultaneous clear_status, restarting the count at 1.
                    if (!locked_s) begin
                        state           <= WAIT_LOCK;
                        reset_out       <= 1'b1;
                        ready           <= 1'b0;
                        lock_lost       <= 1'b1;
                        lock_loss_count <= clear_status ? COUNT_WIDTH'(1) :
                                           (&lock_loss_count) ? lock_loss_count :
                                           lock_loss_count + 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef PLL_LOCK_TIMEOUT_EN
    localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(LOCK_TIMEOUT_CYCLES);

    logic [TW-1:0] tcnt;

    // Held at zero outside WAIT_LOCK, so it starts fresh on every entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt         <= '0;
            lock_timeout <= 1'b0;
        end else begin
            if (state != WAIT_LOCK) tcnt <= '0;
            else if (tcnt != TO_MAX) tcnt <= tcnt + 1'b1;
            if (state == WAIT_LOCK && tcnt == TO_MAX - 1'b1) lock_timeout <= 1'b1;
            else if (clear_status) lock_timeout <= 1'b0;
        end
    end
`else
    assign lock_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
// tb_pll_lock_reset_sequencer: directed checks of lock qualification, loss tracking, async reset and timeout.
module tb_pll_lock_reset_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pll_locked = 1'b0;
    logic       clear_status = 1'b0;
    logic       reset_out, ready, lock_lost, lock_timeout;
    logic [1:0] lock_loss_count;
    int         errors = 0;
    int         checks = 0;
    logic       to_exp;

    always #5 clk = ~clk;

    pll_lock_reset_sequencer #(
        .SYNC_STAGES(2),
        .LOCK_STABLE_CYCLES(8),
        .RESET_HOLD_CYCLES(4),
        .COUNT_WIDTH(2),
        .LOCK_TIMEOUT_CYCLES(20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pll_locked(pll_locked),
        .clear_status(clear_status),
        .reset_out(reset_out),
        .ready(ready),
        .lock_lost(lock_lost),
        .lock_loss_count(lock_loss_count),
        .lock_timeout(lock_timeout)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // pll_locked has just risen with the synchronizer holding zeros: release lands on edge 15.
    task automatic qualify(input string tag);
        tick(14);
        chk({tag, " reset_out@14"}, reset_out, 1);
        chk({tag, " ready@14"}, ready, 0);
        tick(1);
        chk({tag, " reset_out@15"}, reset_out, 0);
        chk({tag, " ready@15"}, ready, 1);
    endtask

    // Drop lock in RUN for 4 cycles; loss takes effect on the third edge.
    task automatic drop_loss(input string tag);
        pll_locked = 1'b0;
        tick(2);
        chk({tag, " ready@2"}, ready, 1);
        tick(1);
        chk({tag, " reset_out@3"}, reset_out, 1);
        chk({tag, " ready@3"}, ready, 0);
        chk({tag, " lost@3"}, lock_lost, 1);
        tick(1);
    endtask

    initial begin
`ifdef PLL_LOCK_TIMEOUT_EN
        to_exp = 1'b1;
`else
        to_exp = 1'b0;
`endif
        tick(2);
        chk("rst reset_out", reset_out, 1);
        chk("rst ready", ready, 0);
        chk("rst lost", lock_lost, 0);
        chk("rst count", lock_loss_count, 0);
        chk("rst timeout", lock_timeout, 0);
        reset = 1'b0;
        tick(3);
        chk("wait reset_out", reset_out, 1);

        pll_locked = 1'b1;
        qualify("first");
        chk("first lost", lock_lost, 0);
        chk("first count", lock_loss_count, 0);

        drop_loss("loss1");
        chk("loss1 count", lock_loss_count, 1);

        pll_locked = 1'b1;
        tick(5);
        chk("glitch ready", ready, 0);
        pll_locked = 1'b0;
        tick(3);
        chk("glitch reset_out", reset_out, 1);
        pll_locked = 1'b1;
        qualify("glitch");
        chk("glitch count", lock_loss_count, 1);

        clear_status = 1'b1;
        tick(1);
        clear_status = 1'b0;
        chk("clear lost", lock_lost, 0);
        chk("clear count", lock_loss_count, 0);
        chk("clear ready", ready, 1);

        for (int i = 1; i <= 5; i++) begin
            drop_loss("sat");
            chk("sat count", lock_loss_count, (i > 3) ? 3 : i);
            pll_locked = 1'b1;
            qualify("sat requal");
        end

        pll_locked = 1'b0;
        tick(2);
        clear_status = 1'b1;
        tick(1);
        clear_status = 1'b0;
        chk("loss+clear reset_out", reset_out, 1);
        chk("loss+clear lost", lock_lost, 1);
        chk("loss+clear count", lock_loss_count, 1);
        tick(1);

        pll_locked = 1'b1;
        tick(12);
        chk("hold ready", ready, 0);
        reset = 1'b1;
        #1;
        chk("async hold reset_out", reset_out, 1);
        chk("async hold lost", lock_lost, 0);
        chk("async hold count", lock_loss_count, 0);
        #2;
        reset = 1'b0;
        qualify("after reset");

        reset = 1'b1;
        #1;
        chk("async run reset_out", reset_out, 1);
        chk("async run ready", ready, 0);
        pll_locked = 1'b0;
        tick(1);
        reset = 1'b0;

        tick(19);
        chk("timeout@19", lock_timeout, 0);
        tick(1);
        chk("timeout@20", lock_timeout, to_exp);
        tick(5);
        chk("timeout sticky", lock_timeout, to_exp);
        chk("timeout reset_out", reset_out, 1);
        clear_status = 1'b1;
        tick(1);
        clear_status = 1'b0;
        chk("timeout cleared", lock_timeout, 0);
        tick(3);
        chk("timeout stays clear", lock_timeout, 0);
        chk("timeout final reset_out", reset_out, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
